// File: rtl/akuma_pkg.sv
// Shared types and constants for the Akuma sprite controllers.
package akuma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WALK_L = 3'd1,
        ST_WALK_R = 3'd2,
        ST_CROUCH = 3'd3,
        ST_JUMP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } air_dir_e;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned SPRITE_W = 140;
    localparam int unsigned SPRITE_H = 240;

    localparam int unsigned POS_W  = 10;
    localparam int unsigned VY_W   = 8;
    localparam int unsigned DIV_W  = 4;
    localparam int unsigned DASH_W = 4;
    localparam int unsigned COOL_W = 5;

    localparam int unsigned DASH_TICKS = 8;
    localparam int unsigned DASH_COOL  = 30;

    // Saturate a signed candidate position into [lo, hi].
    function automatic logic [POS_W-1:0] sat_pos(input logic signed [POS_W:0] v,
                                                 input logic [POS_W-1:0] lo,
                                                 input logic [POS_W-1:0] hi);
        if (v < $signed({1'b0, lo}))
            return lo;
        else if (v > $signed({1'b0, hi}))
            return hi;
        else
            return v[POS_W-1:0];
    endfunction

endpackage

// File: rtl/akuma_motion_if.sv
// Keycode/vsync inputs and sprite anchor/animation outputs of akuma_motion.
interface akuma_motion_if;
    import akuma_pkg::*;

    logic             vs;
    logic [7:0]       keycode;
    logic [POS_W-1:0] AkumaX;
    logic [POS_W-1:0] AkumaY;
    logic [2:0]       anim_state;
    logic [1:0]       anim_frame;
    logic             facing_left;
    logic             frame_tick;

    modport master (
        output vs, keycode,
        input  AkumaX, AkumaY, anim_state, anim_frame, facing_left, frame_tick
    );

    modport slave (
        input  vs, keycode,
        output AkumaX, AkumaY, anim_state, anim_frame, facing_left, frame_tick
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Registered one-cycle pulse on each falling edge of an active-low vsync.
module frame_tick_gen (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vs_n,
    output logic o_tick
);

    logic r_vs_d;
    logic r_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_d <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_vs_d <= i_vs_n;
            r_tick <= r_vs_d & ~i_vs_n;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/akuma_motion.sv
// Akuma sprite motion FSM: keycode-driven walk/crouch/jump, updated once per frame.
// Optional dash move on space is built only when AKUMA_DASH_EN is defined.
module akuma_motion
    import akuma_pkg::*;
#(
    parameter logic [POS_W-1:0] SPAWN_X   = 10'd100,
    parameter logic [POS_W-1:0] X_MIN     = 10'd0,
    parameter logic [POS_W-1:0] X_MAX     = POS_W'(SCREEN_W - SPRITE_W - 1),
    parameter logic [POS_W-1:0] GROUND_Y  = POS_W'(SCREEN_H - SPRITE_H),
    parameter logic [3:0]       WALK_STEP = 4'd3,
    parameter logic [5:0]       JUMP_V0   = 6'd12,
    parameter logic [5:0]       GRAVITY   = 6'd1,
    parameter logic [3:0]       WALK_DIV  = 4'd6
) (
    input  logic          vga_clk,
    input  logic          Reset,
    akuma_motion_if.slave bus
);

    localparam logic signed [POS_W:0] STEP_1X = $signed((POS_W+1)'(WALK_STEP));
    localparam logic signed [POS_W:0] STEP_2X = STEP_1X <<< 1;

    logic                    w_tick;
    logic [7:0]              w_key;
    state_e                  r_state, w_state_nxt;
    logic [POS_W-1:0]        r_x, w_x_nxt;
    logic [POS_W-1:0]        r_y, w_y_nxt;
    logic signed [VY_W-1:0]  r_vy, w_vy_nxt;
    logic [DIV_W-1:0]        r_div, w_div_nxt;
    logic [1:0]              r_frame, w_frame_nxt;
    logic                    r_facing, w_facing_nxt;
    air_dir_e                r_air, w_air_nxt;
    logic signed [POS_W:0]   w_step, w_dx, w_x_sum, w_y_sum;
`ifdef AKUMA_DASH_EN
    logic [DASH_W-1:0]       r_dash, w_dash_nxt;
    logic [COOL_W-1:0]       r_cool, w_cool_nxt;
    logic                    w_walking, w_dash_start;
`endif

    frame_tick_gen u_frame_tick (
        .i_clk  (vga_clk),
        .i_rst  (Reset),
        .i_vs_n (bus.vs),
        .o_tick (w_tick)
    );

    assign w_key = bus.keycode;

    // Next-state values; only committed on a frame tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_y_nxt      = r_y;
        w_vy_nxt     = r_vy;
        w_div_nxt    = r_div;
        w_frame_nxt  = r_frame;
        w_facing_nxt = r_facing;
        w_air_nxt    = r_air;
        w_dx         = '0;
        w_step       = STEP_1X;
        w_y_sum      = $signed({1'b0, r_y}) +
                       $signed({{(POS_W+1-VY_W){r_vy[VY_W-1]}}, r_vy});
`ifdef AKUMA_DASH_EN
        w_dash_nxt   = r_dash;
        w_cool_nxt   = r_cool;
        w_walking    = (r_state == ST_WALK_L) || (r_state == ST_WALK_R);
        w_dash_start = w_walking && (w_key == KEY_SPACE) &&
                       (r_dash == '0) && (r_cool == '0);
        if (w_dash_start || (r_dash != '0))
            w_step = STEP_2X;
`endif

        case (r_state)
            ST_JUMP: begin
                w_vy_nxt = r_vy + $signed(VY_W'(GRAVITY));
                case (r_air)
                    DIR_L:   w_dx = -STEP_1X;
                    DIR_R:   w_dx = STEP_1X;
                    default: w_dx = '0;
                endcase
                if (w_y_sum >= $signed({1'b0, GROUND_Y})) begin
                    w_y_nxt     = GROUND_Y;
                    w_vy_nxt    = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_y_sum[POS_W]) begin
                    w_y_nxt = '0;
                end else begin
                    w_y_nxt = w_y_sum[POS_W-1:0];
                end
            end
            default: begin
                if (w_key == KEY_W) begin
                    w_state_nxt = ST_JUMP;
                    w_vy_nxt    = -$signed(VY_W'(JUMP_V0));
                    w_air_nxt   = (r_state == ST_WALK_L) ? DIR_L :
                                  (r_state == ST_WALK_R) ? DIR_R : DIR_NONE;
                end else if (w_key == KEY_S) begin
                    w_state_nxt = ST_CROUCH;
                end else if (w_key == KEY_A) begin
                    w_state_nxt  = ST_WALK_L;
                    w_facing_nxt = 1'b1;
                    w_dx         = -w_step;
                end else if (w_key == KEY_D) begin
                    w_state_nxt  = ST_WALK_R;
                    w_facing_nxt = 1'b0;
                    w_dx         = w_step;
                end
`ifdef AKUMA_DASH_EN
                else if (w_walking && (w_key == KEY_SPACE)) begin
                    w_dx = (r_state == ST_WALK_L) ? -w_step : w_step;
                end
`endif
                else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase

        w_x_sum = $signed({1'b0, r_x}) + w_dx;
        w_x_nxt = sat_pos(w_x_sum, X_MIN, X_MAX);

        // Walk cycle advances only while the next state is a walk state.
        if ((w_state_nxt == ST_WALK_L) || (w_state_nxt == ST_WALK_R)) begin
            if (r_div == WALK_DIV - DIV_W'(1)) begin
                w_div_nxt   = '0;
                w_frame_nxt = r_frame + 2'd1;
            end else begin
                w_div_nxt = r_div + DIV_W'(1);
            end
        end else begin
            w_div_nxt   = '0;
            w_frame_nxt = '0;
        end

`ifdef AKUMA_DASH_EN
        // The start tick is the first dash tick; a jump cancels into cooldown.
        if (w_dash_start) begin
            w_dash_nxt = DASH_W'(DASH_TICKS - 1);
        end else if ((w_state_nxt == ST_JUMP) && (r_state != ST_JUMP) && (r_dash != '0)) begin
            w_dash_nxt = '0;
            w_cool_nxt = COOL_W'(DASH_COOL);
        end else if (r_dash != '0) begin
            w_dash_nxt = r_dash - DASH_W'(1);
            if (r_dash == DASH_W'(1))
                w_cool_nxt = COOL_W'(DASH_COOL);
        end else if (r_cool != '0) begin
            w_cool_nxt = r_cool - COOL_W'(1);
        end
`endif
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_x      <= SPAWN_X;
            r_y      <= GROUND_Y;
            r_vy     <= '0;
            r_div    <= '0;
            r_frame  <= '0;
            r_facing <= 1'b0;
            r_air    <= DIR_NONE;
        end else if (w_tick) begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_vy     <= w_vy_nxt;
            r_div    <= w_div_nxt;
            r_frame  <= w_frame_nxt;
            r_facing <= w_facing_nxt;
            r_air    <= w_air_nxt;
        end
    end

`ifdef AKUMA_DASH_EN
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_dash <= '0;
            r_cool <= '0;
        end else if (w_tick) begin
            r_dash <= w_dash_nxt;
            r_cool <= w_cool_nxt;
        end
    end
`endif

    assign bus.AkumaX      = r_x;
    assign bus.AkumaY      = r_y;
    assign bus.anim_state  = r_state;
    assign bus.anim_frame  = r_frame;
    assign bus.facing_left = r_facing;
    assign bus.frame_tick  = w_tick;

endmodule

// File: tb/tb_akuma_motion.sv
// Directed, table-driven bench for akuma_motion (default build).
module tb_akuma_motion;

    typedef struct {
        logic [7:0] key;
        int         x;
        int         y;
        int         st;
        int         fr;
        int         fl;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   tick_cnt = 0;
    int   t0;
    vec_t tbl [19];
    int   jy [25] = '{228, 217, 207, 198, 190, 183, 177, 172, 168, 165, 163, 162, 162,
                      163, 165, 168, 172, 177, 183, 190, 198, 207, 217, 228, 240};
    logic [7:0] air_keys [5] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h00};

    always #5 clk = ~clk;

    akuma_motion_if bus ();

    akuma_motion dut (
        .vga_clk (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    always @(posedge clk) if (bus.frame_tick) tick_cnt <= tick_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int y, input int st,
                           input int fr, input int fl);
        chk({tag, " X"}, int'(bus.AkumaX), x);
        chk({tag, " Y"}, int'(bus.AkumaY), y);
        chk({tag, " state"}, int'(bus.anim_state), st);
        chk({tag, " frame"}, int'(bus.anim_frame), fr);
        chk({tag, " facing"}, int'(bus.facing_left), fl);
    endtask

    // One video frame: vs low with key held across the update edge, then vs high.
    task automatic frame(input logic [7:0] k);
        @(negedge clk);
        bus.keycode = k;
        bus.vs      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        repeat (2) @(negedge clk);
        bus.vs      = 1'b1;
        bus.keycode = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tbl = '{
            '{8'h07, 106, 240, 2, 0, 0}, '{8'h07, 109, 240, 2, 0, 0},
            '{8'h07, 112, 240, 2, 0, 0}, '{8'h07, 115, 240, 2, 0, 0},
            '{8'h07, 118, 240, 2, 0, 0}, '{8'h07, 121, 240, 2, 1, 0},
            '{8'h07, 124, 240, 2, 1, 0}, '{8'h07, 127, 240, 2, 1, 0},
            '{8'h07, 130, 240, 2, 1, 0}, '{8'h07, 133, 240, 2, 1, 0},
            '{8'h07, 136, 240, 2, 1, 0}, '{8'h07, 139, 240, 2, 2, 0},
            '{8'h04, 136, 240, 1, 2, 1}, '{8'h04, 133, 240, 1, 2, 1},
            '{8'h16, 133, 240, 3, 0, 1}, '{8'h00, 133, 240, 0, 0, 1},
            '{8'h55, 133, 240, 0, 0, 1}, '{8'h07, 136, 240, 2, 0, 0},
            '{8'h00, 136, 240, 0, 0, 0}
        };

        bus.vs      = 1'b1;
        bus.keycode = 8'h00;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 100, 240, 0, 0, 0);
        chk("reset tick", int'(bus.frame_tick), 0);
        @(negedge clk);
        rst = 1'b0;

        t0 = tick_cnt;
        repeat (5) frame(8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("idle tick count", tick_cnt - t0, 5);
        chk_all("idle", 100, 240, 0, 0, 0);

        // Key present only between ticks must be ignored.
        @(negedge clk);
        bus.keycode = 8'h07;
        repeat (4) @(negedge clk);
        bus.keycode = 8'h00;
        frame(8'h00);
        chk("glitch X", int'(bus.AkumaX), 100);
        chk("glitch state", int'(bus.anim_state), 0);

        // Cycle-accurate view of one update: hold during the tick, move after.
        @(negedge clk);
        bus.keycode = 8'h07;
        bus.vs      = 1'b0;
        @(posedge clk);
        #1;
        chk("tick pulse", int'(bus.frame_tick), 1);
        chk("hold during tick X", int'(bus.AkumaX), 100);
        @(posedge clk);
        #1;
        chk("tick end", int'(bus.frame_tick), 0);
        chk("after tick X", int'(bus.AkumaX), 103);
        chk("after tick state", int'(bus.anim_state), 2);
        @(negedge clk);
        bus.vs      = 1'b1;
        bus.keycode = 8'h00;
        repeat (2) @(negedge clk);
        frame(8'h00);
        chk_all("back idle", 103, 240, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            frame(tbl[i].key);
            chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].fr, tbl[i].fl);
        end

        // Left edge saturation.
        repeat (44) frame(8'h04);
        chk("left X=4", int'(bus.AkumaX), 4);
        frame(8'h04);
        chk("left X=1", int'(bus.AkumaX), 1);
        frame(8'h04);
        chk("left sat 0", int'(bus.AkumaX), 0);
        frame(8'h04);
        chk("left hold 0", int'(bus.AkumaX), 0);
        chk("left state", int'(bus.anim_state), 1);

        // Right edge saturation.
        repeat (166) frame(8'h07);
        chk("right X=498", int'(bus.AkumaX), 498);
        frame(8'h07);
        chk("right sat 499", int'(bus.AkumaX), 499);
        frame(8'h07);
        chk("right hold 499", int'(bus.AkumaX), 499);

        // Standing jump with keys mashed mid-air.
        frame(8'h00);
        frame(8'h1A);
        chk_all("jump start", 499, 240, 4, 0, 0);
        for (int i = 0; i < 25; i++) begin
            frame(air_keys[i % 5]);
            chk($sformatf("jump Y f%0d", i + 1), int'(bus.AkumaY), jy[i]);
            chk($sformatf("jump st f%0d", i + 1), int'(bus.anim_state), (i < 24) ? 4 : 0);
        end
        chk_all("landed", 499, 240, 0, 0, 0);

        // Leftward jump, then reset mid-air.
        frame(8'h04);
        chk_all("pre jump walk", 496, 240, 1, 0, 1);
        frame(8'h1A);
        chk_all("walk jump start", 496, 240, 4, 0, 1);
        repeat (6) frame(8'h00);
        chk_all("mid air", 478, 183, 4, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("mid-air reset", 100, 240, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        frame(8'h00);
        chk("post reset Y", int'(bus.AkumaY), 240);
        chk("post reset state", int'(bus.anim_state), 0);
        frame(8'h1A);
        frame(8'h00);
        chk("rejump Y", int'(bus.AkumaY), 228);
        chk("rejump X", int'(bus.AkumaX), 100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
